// File: rtl/array_seq_pkg.sv
// Shared types for the systolic-array sequencer.
// State encoding, instruction codes and a small sizing helper.
package array_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    W_LOAD,
    W_KERN,
    W_GAP,
    A_LOAD,
    A_EXEC,
    A_DRAIN,
    W_CLR,
    DONE
  } state_e;

  localparam logic [1:0] INST_IDLE  = 2'b00;
  localparam logic [1:0] INST_KLOAD = 2'b01;
  localparam logic [1:0] INST_EXEC  = 2'b10;

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/array_seq_agen.sv
// Address generator for the activation/weight SRAM and psum SRAM.
// Addresses are forced to zero when the matching port is idle.
module array_seq_agen
  import array_seq_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int ACT_LEN  = 36,
  parameter int W_BASE   = 0,
  parameter int ACT_BASE = 72,
  parameter int AW_AW    = 7,
  parameter int PS_AW    = 9,
  parameter int KW       = 4,
  parameter int CW       = 6,
  parameter int WW       = 6
) (
  input  logic             aw_en,
  input  logic             aw_sel,
  input  logic             ps_en,
  input  logic [KW-1:0]    kij_idx,
  input  logic [CW-1:0]    cnt,
  input  logic [WW-1:0]    wb_cnt,
  output logic [AW_AW-1:0] aw_addr,
  output logic [PS_AW-1:0] ps_addr
);

  always_comb begin
    aw_addr = '0;
    ps_addr = '0;
    if (aw_en) begin
      if (aw_sel)
        aw_addr = AW_AW'(W_BASE + ROW * int'(kij_idx)
                         + int'(cnt));
      else
        aw_addr = AW_AW'(ACT_BASE + int'(cnt));
    end
    if (ps_en)
      ps_addr = PS_AW'(ACT_LEN * int'(kij_idx)
                       + int'(wb_cnt));
  end

endmodule

// File: rtl/array_seq_ctrl.sv
// Kernel-position sequencer for the systolic array.
// Optional l0_full stall counter under ARRAY_SEQ_STALL_CNT_EN.
module array_seq_ctrl
  import array_seq_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int KIJ_NUM  = 9,
  parameter int ACT_LEN  = 36,
  parameter int W_BASE   = 0,
  parameter int ACT_BASE = 72,
  parameter int AW_AW    = 7,
  parameter int PS_AW    = 9
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seq_begin,
  input  logic                       seq_abort,
  output logic                       seq_done,
  output logic                       busy,
  output logic [AW_AW-1:0]           aw_addr,
  output logic                       aw_cen,
  output logic                       aw_sel,
  output logic                       l0_wr,
  output logic                       l0_rd,
  input  logic                       l0_full,
  output logic [1:0]                 inst_w,
  output logic                       weight_reset,
  input  logic                       ofifo_valid,
  output logic                       ofifo_rd,
  output logic [PS_AW-1:0]           ps_addr,
  output logic                       ps_cen,
  output logic                       ps_wen,
  output logic [$clog2(KIJ_NUM)-1:0] kij_idx
`ifdef ARRAY_SEQ_STALL_CNT_EN
  ,
  output logic [15:0]                stall_cnt
`endif
);

  localparam int CMAX = max2(max2(ROW + COL, ACT_LEN), ROW);
  localparam int CW   = $clog2(CMAX + 1);
  localparam int WW   = $clog2(ACT_LEN + 1);
  localparam int KW   = $clog2(KIJ_NUM);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wb_q, wb_d;
  logic [KW-1:0] kij_q, kij_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] lim;
  logic          loading;
  logic          issue;
  logic          wb_en;

  assign loading = (state_q == W_LOAD) || (state_q == A_LOAD);
  assign lim     = (state_q == A_LOAD) ? CW'(ACT_LEN) : CW'(ROW);
  assign issue   = loading && (cnt_q < lim) && !l0_full;
  assign wb_en   = (state_q != IDLE) && ofifo_valid
                   && (wb_q < WW'(ACT_LEN));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wb_d         = wb_q;
    kij_d        = kij_q;
    pend_d       = issue;
    aw_sel       = 1'b0;
    l0_rd        = 1'b0;
    inst_w       = INST_IDLE;
    weight_reset = 1'b0;
    seq_done     = 1'b0;
    if (wb_en) wb_d = wb_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (seq_begin) begin
          state_d = W_LOAD;
          cnt_d   = '0;
          kij_d   = '0;
          wb_d    = '0;
        end
      end
      W_LOAD, A_LOAD: begin
        aw_sel = (state_q == W_LOAD);
        if (issue) cnt_d = cnt_q + 1'b1;
        // last write lands the cycle after the last read
        if (cnt_q == lim && pend_q) begin
          state_d = (state_q == W_LOAD) ? W_KERN : A_EXEC;
          cnt_d   = '0;
        end
      end
      W_KERN: begin
        l0_rd  = 1'b1;
        inst_w = INST_KLOAD;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(COL - 1)) begin
          state_d = W_GAP;
          cnt_d   = '0;
        end
      end
      W_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ROW + COL - 1)) begin
          state_d = A_LOAD;
          cnt_d   = '0;
        end
      end
      A_EXEC: begin
        l0_rd  = 1'b1;
        inst_w = INST_EXEC;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(ACT_LEN - 1)) begin
          state_d = A_DRAIN;
          cnt_d   = '0;
        end
      end
      A_DRAIN: begin
        if (wb_q == WW'(ACT_LEN)) begin
          state_d = W_CLR;
          wb_d    = '0;
        end
      end
      W_CLR: begin
        weight_reset = 1'b1;
        if (kij_q == KW'(KIJ_NUM - 1)) begin
          state_d = DONE;
        end else begin
          kij_d   = kij_q + 1'b1;
          state_d = W_LOAD;
        end
      end
      DONE: begin
        seq_done = !seq_abort;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (seq_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      wb_d    = '0;
      kij_d   = '0;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wb_q    <= '0;
      kij_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      kij_q   <= kij_d;
      pend_q  <= pend_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign aw_cen   = !issue;
  assign l0_wr    = pend_q;
  assign ofifo_rd = wb_en;
  assign ps_cen   = !wb_en;
  assign ps_wen   = !wb_en;
  assign kij_idx  = kij_q;

  array_seq_agen #(
    .ROW      (ROW),
    .ACT_LEN  (ACT_LEN),
    .W_BASE   (W_BASE),
    .ACT_BASE (ACT_BASE),
    .AW_AW    (AW_AW),
    .PS_AW    (PS_AW),
    .KW       (KW),
    .CW       (CW),
    .WW       (WW)
  ) u_agen (
    .aw_en   (issue),
    .aw_sel  (aw_sel),
    .ps_en   (wb_en),
    .kij_idx (kij_q),
    .cnt     (cnt_q),
    .wb_cnt  (wb_q),
    .aw_addr (aw_addr),
    .ps_addr (ps_addr)
  );

`ifdef ARRAY_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && seq_begin && !seq_abort)
      stall_d = '0;
    else if (loading && cnt_q < lim && l0_full
             && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
